// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only HD44780 strobe sequencer driven by a GO-toggle register.
// Define LCD_INIT_EN to compile in the autonomous power-up init sequence.
module lcd_ctrl #(
    parameter int SETUP_CYC      = 4,
    parameter int PULSE_CYC      = 12,
    parameter int HOLD_CYC       = 4,
    parameter int WAIT_CYC       = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int INIT_DELAY_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, WAIT_CYC)),
                                  max2(LONG_WAIT_CYC, INIT_DELAY_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Phase counters count up from 0 and leave each phase on its last cycle.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_DELAY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT, ST_INIT_DLY
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    localparam state_t RESET_STATE = ST_INIT_DLY;
    logic [1:0] init_idx_q;
    logic       init_run_q;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT
    } state_t;

    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_go_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             en_q;
    logic             busy_q;
    logic             on_q;

    logic             go_req;
    logic             long_wait;
    logic [CNT_W-1:0] wait_last;
    logic             unused_io;

    // Clear/home commands (0x01..0x03 with RS=0) need the long execution wait.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        go_req    = (state_q == ST_IDLE) && (io_lcd_i[11] != last_go_q);
        long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
        wait_last = long_wait ? LONG_LAST : WAIT_LAST;
    end

    assign unused_io = ^{io_lcd_i[30:12], io_lcd_i[10], io_lcd_i[8]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            last_go_q  <= io_lcd_i[11];
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            on_q       <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q <= 2'd0;
            init_run_q <= 1'b1;
`endif
        end else begin
            on_q <= io_lcd_i[31];
            case (state_q)
                ST_IDLE: begin
                    if (go_req) begin
                        rs_q      <= io_lcd_i[9];
                        data_q    <= io_lcd_i[7:0];
                        last_go_q <= io_lcd_i[11];
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b1;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == wait_last) begin
                        cnt_q <= '0;
`ifdef LCD_INIT_EN
                        // During power-up, chain straight into the next ROM command.
                        if (init_run_q && (init_idx_q != 2'd3)) begin
                            init_idx_q <= init_idx_q + 2'd1;
                            data_q     <= init_cmd(init_idx_q + 2'd1);
                            state_q    <= ST_SETUP;
                        end else begin
                            init_run_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef LCD_INIT_EN
                ST_INIT_DLY: begin
                    busy_q <= 1'b1;
                    if (cnt_q == INIT_LAST) begin
                        cnt_q      <= '0;
                        rs_q       <= 1'b0;
                        data_q     <= init_cmd(2'd0);
                        init_idx_q <= 2'd0;
                        state_q    <= ST_SETUP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                default: begin
                    cnt_q   <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_en_o   = en_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl; expected transfers are queued when GO
// is toggled and popped when an EN pulse starts. Define LCD_INIT_EN to cover power-up.
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int SETUP_CYC      = 2;
    localparam int PULSE_CYC      = 3;
    localparam int HOLD_CYC       = 2;
    localparam int WAIT_CYC       = 5;
    localparam int LONG_WAIT_CYC  = 20;
    localparam int INIT_DELAY_CYC = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] io_lcd_i = 32'h0;
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o;

    lcd_ctrl #(
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC),
        .WAIT_CYC(WAIT_CYC), .LONG_WAIT_CYC(LONG_WAIT_CYC), .INIT_DELAY_CYC(INIT_DELAY_CYC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .io_lcd_i(io_lcd_i),
        .lcd_on_o(lcd_on_o), .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o),
        .lcd_rw_o(lcd_rw_o), .lcd_data_o(lcd_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xfer_t;

    xfer_t expQ[$];
    xfer_t monExp;
    int    checks = 0;
    int    errors = 0;
    logic  goBit  = 1'b0;
    logic  enPrev = 1'b0;

    // Every rising EN must match the oldest outstanding expected transfer.
    always @(negedge clk_i) begin
        if (lcd_en_o && !enPrev) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_pulse: got rs=%0b data=%02h, required no transfer",
                         lcd_rs_o, lcd_data_o);
            end else begin
                monExp = expQ.pop_front();
                if ({lcd_rs_o, lcd_data_o} !== {monExp.rs, monExp.data}) begin
                    errors++;
                    $display("[TB] FAIL sb_transfer: got rs=%0b data=%02h, required rs=%0b data=%02h",
                             lcd_rs_o, lcd_data_o, monExp.rs, monExp.data);
                end
            end
        end
        enPrev = lcd_en_o;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive_go(input logic on, input logic rs, input logic [7:0] data);
        goBit    = ~goBit;
        io_lcd_i = {on, 19'd0, goBit, 1'b0, rs, 1'b0, data};
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] data);
        xfer_t e;
        e.rs   = rs;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Samples outputs on cycles 1..n after the next rising edge; bit k = cycle k.
    task automatic watch(input int n, output logic [127:0] enVec, output logic [127:0] busyVec,
                         output logic rs1, output logic [7:0] data1, output logic changed);
        enVec   = '0;
        busyVec = '0;
        rs1     = 1'b0;
        data1   = 8'h00;
        changed = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            enVec[k]   = lcd_en_o;
            busyVec[k] = busy_o;
            if (k == 1) begin
                rs1   = lcd_rs_o;
                data1 = lcd_data_o;
            end else if ({lcd_rs_o, lcd_data_o} !== {rs1, data1}) begin
                changed = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        rst_i    = 1'b1;
        goBit    = 1'b1;
        io_lcd_i = 32'h0000_0800;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({lcd_en_o, lcd_rs_o, lcd_data_o, lcd_on_o, busy_o} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got en=%0b rs=%0b data=%02h on=%0b busy=%0b, required all 0",
                     lcd_en_o, lcd_rs_o, lcd_data_o, lcd_on_o, busy_o);
        end
`ifdef LCD_INIT_EN
        push_exp(1'b0, 8'h38);
        push_exp(1'b0, 8'h0C);
        push_exp(1'b0, 8'h01);
        push_exp(1'b0, 8'h06);
        rst_i = 1'b0;
        watch(90, enVec, busyVec, rs1, data1, changed);
        checks++;
        if (enVec !== (span(12, 14) | span(24, 26) | span(36, 38) | span(63, 65))) begin
            errors++;
            $display("[TB] FAIL init_en_timing: got %h, required %h", enVec,
                     span(12, 14) | span(24, 26) | span(36, 38) | span(63, 65));
        end
        checks++;
        if (busyVec !== span(1, 72)) begin
            errors++;
            $display("[TB] FAIL init_busy: got %h, required %h", busyVec, span(1, 72));
        end
`else
        rst_i = 1'b0;
        watch(30, enVec, busyVec, rs1, data1, changed);
        checks++;
        if (enVec !== '0) begin
            errors++;
            $display("[TB] FAIL idle_no_en: got %h, required 0", enVec);
        end
        checks++;
        if (busyVec !== '0) begin
            errors++;
            $display("[TB] FAIL idle_busy: got %h, required 0", busyVec);
        end
        checks++;
        if ({rs1, data1, changed, lcd_on_o, lcd_rw_o} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got rs=%0b data=%02h chg=%0b on=%0b rw=%0b, required all 0",
                     rs1, data1, changed, lcd_on_o, lcd_rw_o);
        end
`endif
        io_lcd_i[31] = 1'b1;
        @(negedge clk_i);
        checks++;
        if (lcd_on_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL on_follow_high: got %0b, required 1", lcd_on_o);
        end
        io_lcd_i[31] = 1'b0;
        @(negedge clk_i);
        checks++;
        if (lcd_on_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL on_follow_low: got %0b, required 0", lcd_on_o);
        end
    endtask

    task automatic test_data_write();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        push_exp(1'b1, 8'h41);
        drive_go(1'b1, 1'b1, 8'h41);
        watch(20, enVec, busyVec, rs1, data1, changed);
        checks++;
        if (enVec !== span(3, 5)) begin
            errors++;
            $display("[TB] FAIL data_en: got %h, required %h", enVec, span(3, 5));
        end
        checks++;
        if (busyVec !== span(1, 12)) begin
            errors++;
            $display("[TB] FAIL data_busy: got %h, required %h", busyVec, span(1, 12));
        end
        checks++;
        if ({rs1, data1, changed} !== {1'b1, 8'h41, 1'b0}) begin
            errors++;
            $display("[TB] FAIL data_regs: got rs=%0b data=%02h chg=%0b, required rs=1 data=41 chg=0",
                     rs1, data1, changed);
        end
        checks++;
        if ({lcd_on_o, lcd_rw_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL data_on_rw: got on=%0b rw=%0b, required on=1 rw=0", lcd_on_o, lcd_rw_o);
        end
        io_lcd_i[31] = 1'b0;
    endtask

    task automatic test_wait_select();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        logic       tRs[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] tData[7] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h01, 8'h80};
        int         tLast[7] = '{27, 27, 27, 12, 12, 12, 12};
        for (int i = 0; i < 7; i++) begin
            push_exp(tRs[i], tData[i]);
            drive_go(1'b0, tRs[i], tData[i]);
            watch(32, enVec, busyVec, rs1, data1, changed);
            checks++;
            if (enVec !== span(3, 5)) begin
                errors++;
                $display("[TB] FAIL wait_en[%0d]: got %h, required %h", i, enVec, span(3, 5));
            end
            checks++;
            if (busyVec !== span(1, tLast[i])) begin
                errors++;
                $display("[TB] FAIL wait_busy[%0d] rs=%0b data=%02h: got %h, required %h",
                         i, tRs[i], tData[i], busyVec, span(1, tLast[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        push_exp(1'b1, 8'h10);
        drive_go(1'b0, 1'b1, 8'h10);
        fork
            watch(24, enVec, busyVec, rs1, data1, changed);
            begin
                repeat (4) @(negedge clk_i);
                drive_go(1'b0, 1'b1, 8'h20);
                repeat (2) @(negedge clk_i);
                drive_go(1'b0, 1'b1, 8'h30);
            end
        join
        checks++;
        if ((enVec !== span(3, 5)) || (busyVec !== span(1, 12))) begin
            errors++;
            $display("[TB] FAIL even_toggle: got en=%h busy=%h, required en=%h busy=%h",
                     enVec, busyVec, span(3, 5), span(1, 12));
        end
        push_exp(1'b0, 8'h55);
        drive_go(1'b0, 1'b0, 8'h55);
        watch(20, enVec, busyVec, rs1, data1, changed);
        checks++;
        if ((enVec !== span(3, 5)) || (busyVec !== span(1, 12)) || ({rs1, data1} !== {1'b0, 8'h55})) begin
            errors++;
            $display("[TB] FAIL after_even: got en=%h busy=%h rs=%0b data=%02h, required single 0/55 transfer",
                     enVec, busyVec, rs1, data1);
        end
    endtask

    task automatic test_odd_toggle();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        push_exp(1'b1, 8'hA1);
        push_exp(1'b0, 8'hC3);
        drive_go(1'b0, 1'b1, 8'hA1);
        fork
            watch(40, enVec, busyVec, rs1, data1, changed);
            begin
                repeat (5) @(negedge clk_i);
                drive_go(1'b0, 1'b1, 8'hB2);
                repeat (3) @(negedge clk_i);
                io_lcd_i[9]   = 1'b0;
                io_lcd_i[7:0] = 8'hC3;
            end
        join
        checks++;
        if (enVec !== (span(3, 5) | span(16, 18))) begin
            errors++;
            $display("[TB] FAIL odd_en: got %h, required %h", enVec, span(3, 5) | span(16, 18));
        end
        checks++;
        if (busyVec !== (span(1, 12) | span(14, 25))) begin
            errors++;
            $display("[TB] FAIL odd_busy: got %h, required %h", busyVec, span(1, 12) | span(14, 25));
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [127:0] enVec, busyVec;
        logic rs1, changed;
        logic [7:0] data1;
        push_exp(1'b1, 8'hA5);
        drive_go(1'b0, 1'b1, 8'hA5);
        repeat (3) @(negedge clk_i);
        checks++;
        if (lcd_en_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_in_pulse: got en=%0b, required 1", lcd_en_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({lcd_en_o, busy_o, lcd_rs_o, lcd_data_o} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got en=%0b busy=%0b rs=%0b data=%02h, required all 0",
                     lcd_en_o, busy_o, lcd_rs_o, lcd_data_o);
        end
        rst_i = 1'b0;
`ifdef LCD_INIT_EN
        push_exp(1'b0, 8'h38);
        push_exp(1'b0, 8'h0C);
        push_exp(1'b0, 8'h01);
        push_exp(1'b0, 8'h06);
        watch(90, enVec, busyVec, rs1, data1, changed);
        checks++;
        if (busyVec[90] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reinit_done: got busy=%0b, required 0", busyVec[90]);
        end
`else
        watch(15, enVec, busyVec, rs1, data1, changed);
        checks++;
        if ((enVec !== '0) || (busyVec !== '0)) begin
            errors++;
            $display("[TB] FAIL abort_no_resume: got en=%h busy=%h, required 0", enVec, busyVec);
        end
`endif
        push_exp(1'b1, 8'h5A);
        drive_go(1'b0, 1'b1, 8'h5A);
        watch(20, enVec, busyVec, rs1, data1, changed);
        checks++;
        if ((enVec !== span(3, 5)) || (busyVec !== span(1, 12))) begin
            errors++;
            $display("[TB] FAIL post_abort: got en=%h busy=%h, required en=%h busy=%h",
                     enVec, busyVec, span(3, 5), span(1, 12));
        end
    endtask

    initial begin
        @(negedge clk_i);
        $display("[TB] start");
        test_reset();
        test_data_write();
        test_wait_select();
        test_back_to_back();
        test_odd_toggle();
        test_reset_mid_pulse();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d outstanding transfers, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
